// File: rtl/operand_input_conditioner_if.sv
// Operand/button bundle between the switch-and-button front end and the multiplier.
// The master drives the raw inputs; the slave (conditioner) returns the snapshot and pulses.
interface operand_input_conditioner_if #(
    parameter int OP_WIDTH = 4
);
    logic [OP_WIDTH-1:0] a_raw;
    logic [OP_WIDTH-1:0] b_raw;
    logic                load_btn;
    logic                clear_btn;
    logic [OP_WIDTH-1:0] a_q;
    logic [OP_WIDTH-1:0] b_q;
    logic                op_load;
    logic                op_clear;

    modport master (
        output a_raw, b_raw, load_btn, clear_btn,
        input  a_q, b_q, op_load, op_clear
    );

    modport slave (
        input  a_raw, b_raw, load_btn, clear_btn,
        output a_q, b_q, op_load, op_clear
    );
endinterface

// File: rtl/operand_input_conditioner.sv
// Synchronises switches/buttons, debounces LOAD/CLEAR into one-cycle pulses with an operand snapshot.
// Latency DEBOUNCE_CYCLES+2 edges from raw press to pulse; no backpressure, pulses are never held.
module oic_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sync,
    output logic o_accept
);
    localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, PRESS, HELD, REL} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The count never passes CNT_LAST: reaching it always leaves PRESS/REL.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_sync) begin
                    w_state_nxt = PRESS;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            PRESS: begin
                if (!i_sync) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                    o_accept    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            HELD: begin
                if (!i_sync) begin
                    w_state_nxt = REL;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            REL: begin
                if (i_sync) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end
endmodule

module operand_input_conditioner #(
    parameter int OP_WIDTH        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                       clk,
    input  logic                       rst,
    operand_input_conditioner_if.slave bus
);
    logic [OP_WIDTH-1:0] r_a_s1, r_a_s2;
    logic [OP_WIDTH-1:0] r_b_s1, r_b_s2;
    logic                r_l_s1, r_l_s2;
    logic                r_c_s1, r_c_s2;
    logic [OP_WIDTH-1:0] r_a_q, r_b_q;
    logic                r_op_load, r_op_clear;
    logic                w_load_acc, w_clear_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_s1 <= '0;
            r_a_s2 <= '0;
            r_b_s1 <= '0;
            r_b_s2 <= '0;
            r_l_s1 <= 1'b0;
            r_l_s2 <= 1'b0;
            r_c_s1 <= 1'b0;
            r_c_s2 <= 1'b0;
        end else begin
            r_a_s1 <= bus.a_raw;
            r_a_s2 <= r_a_s1;
            r_b_s1 <= bus.b_raw;
            r_b_s2 <= r_b_s1;
            r_l_s1 <= bus.load_btn;
            r_l_s2 <= r_l_s1;
            r_c_s1 <= bus.clear_btn;
            r_c_s2 <= r_c_s1;
        end
    end

    oic_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clk      (clk),
        .rst      (rst),
        .i_sync   (r_l_s2),
        .o_accept (w_load_acc)
    );

    oic_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk      (clk),
        .rst      (rst),
        .i_sync   (r_c_s2),
        .o_accept (w_clear_acc)
    );

    // CLEAR dominates; a LOAD accepted in the same cycle is discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_q      <= '0;
            r_b_q      <= '0;
            r_op_load  <= 1'b0;
            r_op_clear <= 1'b0;
        end else if (w_clear_acc) begin
            r_a_q      <= '0;
            r_b_q      <= '0;
            r_op_load  <= 1'b0;
            r_op_clear <= 1'b1;
        end else if (w_load_acc) begin
            r_a_q      <= r_a_s2;
            r_b_q      <= r_b_s2;
            r_op_load  <= 1'b1;
            r_op_clear <= 1'b0;
        end else begin
            r_op_load  <= 1'b0;
            r_op_clear <= 1'b0;
        end
    end

    assign bus.a_q      = r_a_q;
    assign bus.b_q      = r_b_q;
    assign bus.op_load  = r_op_load;
    assign bus.op_clear = r_op_clear;
endmodule

// File: tb/tb_operand_input_conditioner.sv
// Directed bench for operand_input_conditioner with DEBOUNCE_CYCLES=4 (pulse 6 edges after press).
module tb_operand_input_conditioner;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    operand_input_conditioner_if #(.OP_WIDTH(4)) bus ();

    operand_input_conditioner #(.OP_WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise the chosen buttons, drop them after 'hold' edges, count pulses over 'span' edges.
    task automatic press(input bit ld, input bit cl, input int hold, input int span,
                         output int n_ld, output int n_cl);
        n_ld = 0;
        n_cl = 0;
        bus.load_btn  = ld;
        bus.clear_btn = cl;
        for (int i = 1; i <= span; i++) begin
            tick();
            if (bus.op_load === 1'b1)  n_ld++;
            if (bus.op_clear === 1'b1) n_cl++;
            if (i == hold) begin
                bus.load_btn  = 1'b0;
                bus.clear_btn = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        bus.a_raw = 4'h0; bus.b_raw = 4'h0;
        bus.load_btn = 1'b0; bus.clear_btn = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        total++; if (bus.a_q !== 4'h0) begin bad++; $display("FAIL reset_a_q got=%0h want=0", bus.a_q); end
        total++; if (bus.b_q !== 4'h0) begin bad++; $display("FAIL reset_b_q got=%0h want=0", bus.b_q); end
        total++; if (bus.op_load !== 1'b0) begin bad++; $display("FAIL reset_op_load got=%b want=0", bus.op_load); end
        total++; if (bus.op_clear !== 1'b0) begin bad++; $display("FAIL reset_op_clear got=%b want=0", bus.op_clear); end
        tick(); tick();
        rst = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_clean_load();
        bus.a_raw = 4'hA; bus.b_raw = 4'h3; bus.load_btn = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            total++;
            if (bus.op_load !== (e == 6)) begin
                bad++; $display("FAIL clean_load_pulse edge=%0d got=%b want=%b", e, bus.op_load, (e == 6));
            end
            if (e == 6) begin
                total++; if (bus.a_q !== 4'hA) begin bad++; $display("FAIL clean_load_a_q got=%0h want=a", bus.a_q); end
                total++; if (bus.b_q !== 4'h3) begin bad++; $display("FAIL clean_load_b_q got=%0h want=3", bus.b_q); end
            end
        end
        bus.load_btn = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_bounce();
        int n_ld, n_cl;
        n_ld = 0;
        for (int i = 0; i < 16; i++) begin
            bus.load_btn = (i < 4) ? ((i % 2) == 0) : 1'b0;
            tick();
            if (bus.op_load === 1'b1) n_ld++;
        end
        total++; if (n_ld != 0) begin bad++; $display("FAIL bounce_no_pulse got=%0d want=0", n_ld); end
        press(1'b1, 1'b0, 10, 20, n_ld, n_cl);
        total++; if (n_ld != 1) begin bad++; $display("FAIL bounce_then_hold got=%0d want=1", n_ld); end
    endtask

    task automatic test_switch_change();
        int n_ld, n_cl;
        bus.a_raw = 4'h5; bus.b_raw = 4'h6;
        repeat (3) tick();
        press(1'b1, 1'b0, 10, 20, n_ld, n_cl);
        total++; if (n_ld != 1) begin bad++; $display("FAIL sw_first_load got=%0d want=1", n_ld); end
        total++; if (bus.a_q !== 4'h5) begin bad++; $display("FAIL sw_a_q_5 got=%0h want=5", bus.a_q); end
        total++; if (bus.b_q !== 4'h6) begin bad++; $display("FAIL sw_b_q_6 got=%0h want=6", bus.b_q); end
        bus.a_raw = 4'hF;
        repeat (10) tick();
        total++; if (bus.a_q !== 4'h5) begin bad++; $display("FAIL sw_no_press_hold got=%0h want=5", bus.a_q); end
        press(1'b1, 1'b0, 10, 20, n_ld, n_cl);
        total++; if (bus.a_q !== 4'hF) begin bad++; $display("FAIL sw_a_q_f got=%0h want=f", bus.a_q); end
        total++; if (bus.b_q !== 4'h6) begin bad++; $display("FAIL sw_b_q_kept got=%0h want=6", bus.b_q); end
    endtask

    task automatic test_clear();
        int n_ld, n_cl;
        press(1'b0, 1'b1, 10, 20, n_ld, n_cl);
        total++; if (n_cl != 1) begin bad++; $display("FAIL clear_one_pulse got=%0d want=1", n_cl); end
        total++; if (n_ld != 0) begin bad++; $display("FAIL clear_no_load got=%0d want=0", n_ld); end
        total++; if (bus.a_q !== 4'h0) begin bad++; $display("FAIL clear_a_q got=%0h want=0", bus.a_q); end
        total++; if (bus.b_q !== 4'h0) begin bad++; $display("FAIL clear_b_q got=%0h want=0", bus.b_q); end
        bus.a_raw = 4'h9; bus.b_raw = 4'h4;
        press(1'b1, 1'b0, 10, 20, n_ld, n_cl);
        total++; if (bus.a_q !== 4'h9) begin bad++; $display("FAIL preclear_load_a_q got=%0h want=9", bus.a_q); end
        press(1'b1, 1'b1, 10, 24, n_ld, n_cl);
        total++; if (n_cl != 1) begin bad++; $display("FAIL both_clear got=%0d want=1", n_cl); end
        total++; if (n_ld != 0) begin bad++; $display("FAIL both_load_dropped got=%0d want=0", n_ld); end
        total++; if (bus.a_q !== 4'h0) begin bad++; $display("FAIL both_a_q got=%0h want=0", bus.a_q); end
    endtask

    task automatic test_reset_mid_press();
        int n_ld, n_cl;
        bus.a_raw = 4'h7; bus.b_raw = 4'h2;
        press(1'b1, 1'b0, 10, 20, n_ld, n_cl);
        total++; if (bus.a_q !== 4'h7) begin bad++; $display("FAIL rmp_preload got=%0h want=7", bus.a_q); end
        bus.load_btn = 1'b1;
        n_ld = 0;
        repeat (3) begin
            tick();
            if (bus.op_load === 1'b1) n_ld++;
        end
        rst = 1'b1;
        #1;
        total++; if (bus.a_q !== 4'h0) begin bad++; $display("FAIL rmp_reset_a_q got=%0h want=0", bus.a_q); end
        tick(); tick();
        rst = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (bus.op_load === 1'b1) n_ld++;
            total++;
            if (bus.op_load !== (e == 6)) begin
                bad++; $display("FAIL rmp_pulse edge=%0d got=%b want=%b", e, bus.op_load, (e == 6));
            end
            if (e == 6) begin
                total++; if (bus.a_q !== 4'h7) begin bad++; $display("FAIL rmp_a_q got=%0h want=7", bus.a_q); end
            end
        end
        total++; if (n_ld != 1) begin bad++; $display("FAIL rmp_pulse_count got=%0d want=1", n_ld); end
        bus.load_btn = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        test_reset();
        test_clean_load();
        test_bounce();
        test_switch_change();
        test_clear();
        test_reset_mid_press();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
